// File: rtl/acc_operand_issuer.sv
// acc_operand_issuer
// Transmit-side companion for the accumulate/mask datapath register block.
// Operand triplets (a, b, c) arrive over a valid/ready handshake and are
// buffered in a small FIFO. They are then issued to the datapath as
// registered buses with a one-cycle enable strobe. An optional idle gap can
// follow every issue. A shadow copy of the datapath accumulation,
// d + (a | c), is kept for cross-checking.
//
// Parameters:
//    W      operand / accumulator width
//    DEPTH  FIFO depth in triplets (power of 2, >= 2)
//    GAP    idle cycles after every issue (0 = back-to-back)
//
// Ports:
//    clk         clock, rising edge
//    rst         synchronous active-low reset
//    in_valid    upstream triplet valid
//    in_ready    FIFO can accept (combinational, count != DEPTH)
//    in_a/b/c    incoming operands
//    flush       synchronous clear of FIFO and issue FSM
//    out_en      one-cycle issue strobe (registered)
//    out_a/b/c   issued operands (registered, hold between issues)
//    shadow_acc  running sum of (a | c) over issued triplets, mod 2^W
//    count       FIFO occupancy (registered)
//    issued_cnt  number of issued triplets, wraps at 16 bits
//    busy        FIFO non-empty or FSM not idle
//    out_par     XOR of {out_a, out_b, out_c}; present only when the
//                ACC_ISSUE_PARITY_EN macro is defined
module acc_operand_issuer #(
   parameter int W     = 12,
   parameter int DEPTH = 4,
   parameter int GAP   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_a,
   input  logic [W-1:0]           in_b,
   input  logic [W-1:0]           in_c,
   input  logic                   flush,
   output logic                   out_en,
   output logic [W-1:0]           out_a,
   output logic [W-1:0]           out_b,
   output logic [W-1:0]           out_c,
   output logic [W-1:0]           shadow_acc,
   output logic [$clog2(DEPTH):0] count,
   output logic [15:0]            issued_cnt,
   output logic                   busy
`ifdef ACC_ISSUE_PARITY_EN
   ,
   output logic                   out_par
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // The gap counter only needs to reach GAP-1; keep at least one bit so
   // the declaration stays legal when GAP is 0 or 1.
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [GW-1:0] gap_cnt;
   logic [GW-1:0] gap_next;

   logic [W-1:0]  mem_a [DEPTH];
   logic [W-1:0]  mem_b [DEPTH];
   logic [W-1:0]  mem_c [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic          push;
   logic          pop;

   // in_ready looks only at the registered count, so a full FIFO never
   // accepts a new triplet, even when a pop happens in the same cycle.
   // A push that coincides with flush is dropped.
   assign in_ready = (count != CW'(DEPTH));
   assign push     = in_valid && in_ready && !flush;
   assign busy     = (count != '0) || (state != IDLE);

   // FIFO storage is not reset; only the pointers carry meaning.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem_a[wr_ptr] <= in_a;
         mem_b[wr_ptr] <= in_b;
         mem_c[wr_ptr] <= in_c;
      end
   end

   // Issue FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         state   <= state_next;
         gap_cnt <= gap_next;
      end
   end

   // Next-state logic. IDLE pops whenever data is present. With GAP > 0
   // every issue is followed by GAP cycles in WAIT. The gap counter runs
   // from 0 up to GAP-1.
   always_comb begin
      state_next = state;
      gap_next   = gap_cnt;
      pop        = 1'b0;
      if (flush) begin
         state_next = IDLE;
         gap_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0) begin
                  pop = 1'b1;
                  if (GAP > 0) begin
                     state_next = WAIT;
                     gap_next   = '0;
                  end
               end
            end
            WAIT: begin
               if (gap_cnt == GW'(GAP - 1)) begin
                  state_next = IDLE;
                  gap_next   = '0;
               end else begin
                  gap_next = gap_cnt + GW'(1);
               end
            end
            default: begin
               state_next = IDLE;
               gap_next   = '0;
            end
         endcase
      end
   end

   // Pointers, occupancy and the registered issue outputs. Flush clears the
   // queue and silences the strobe. It leaves the issued data, the shadow
   // accumulator and the issue counter untouched.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         out_en     <= 1'b0;
         out_a      <= '0;
         out_b      <= '0;
         out_c      <= '0;
         shadow_acc <= '0;
         issued_cnt <= '0;
`ifdef ACC_ISSUE_PARITY_EN
         out_par    <= 1'b0;
`endif
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         out_en <= 1'b0;
      end else begin
         out_en <= pop;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            out_a      <= mem_a[rd_ptr];
            out_b      <= mem_b[rd_ptr];
            out_c      <= mem_c[rd_ptr];
            shadow_acc <= shadow_acc + (mem_a[rd_ptr] | mem_c[rd_ptr]);
            issued_cnt <= issued_cnt + 16'd1;
`ifdef ACC_ISSUE_PARITY_EN
            out_par    <= ^{mem_a[rd_ptr], mem_b[rd_ptr], mem_c[rd_ptr]};
`endif
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_acc_operand_issuer.sv
// tb_acc_operand_issuer
// Self-checking bench for acc_operand_issuer. Two instances share one input
// stream: one with GAP = 0 and one with GAP = 3. A queue-style reference
// model predicts every output of both instances cycle by cycle. Directed
// steps exercise the main scenarios, followed by a randomized phase and a
// long run that wraps the 16-bit issue counter. The out_par output is
// checked when ACC_ISSUE_PARITY_EN is defined.
module tb_acc_operand_issuer;

   localparam int W     = 12;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          flush;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [W-1:0]  in_c;

   logic          rdy   [2];
   logic          en    [2];
   logic [W-1:0]  oa    [2];
   logic [W-1:0]  ob    [2];
   logic [W-1:0]  oc    [2];
   logic [W-1:0]  acc   [2];
   logic [CW-1:0] cnt   [2];
   logic [15:0]   icnt  [2];
   logic          bsy   [2];
`ifdef ACC_ISSUE_PARITY_EN
   logic          par   [2];
`endif

   // Reference model state: a ring of pending triplets per instance, the
   // number of idle cycles still owed after the last issue, and the
   // expected registered outputs.
   logic [W-1:0]  qa    [2][8];
   logic [W-1:0]  qb    [2][8];
   logic [W-1:0]  qc    [2][8];
   int            m_head [2];
   int            m_size [2];
   int            m_gap  [2];
   logic          m_en   [2];
   logic [W-1:0]  m_a    [2];
   logic [W-1:0]  m_b    [2];
   logic [W-1:0]  m_c    [2];
   logic [W-1:0]  m_acc  [2];
   logic [15:0]   m_icnt [2];

   int errors;
   int checks;
   int idx;
   logic [W-1:0] saved_acc;

   acc_operand_issuer #(.W(W), .DEPTH(DEPTH), .GAP(0)) dut_g0 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (rdy[0]),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_c       (in_c),
      .flush      (flush),
      .out_en     (en[0]),
      .out_a      (oa[0]),
      .out_b      (ob[0]),
      .out_c      (oc[0]),
      .shadow_acc (acc[0]),
      .count      (cnt[0]),
      .issued_cnt (icnt[0]),
      .busy       (bsy[0])
`ifdef ACC_ISSUE_PARITY_EN
      ,
      .out_par    (par[0])
`endif
   );

   acc_operand_issuer #(.W(W), .DEPTH(DEPTH), .GAP(3)) dut_g3 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (rdy[1]),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_c       (in_c),
      .flush      (flush),
      .out_en     (en[1]),
      .out_a      (oa[1]),
      .out_b      (ob[1]),
      .out_c      (oc[1]),
      .shadow_acc (acc[1]),
      .count      (cnt[1]),
      .issued_cnt (icnt[1]),
      .busy       (bsy[1])
`ifdef ACC_ISSUE_PARITY_EN
      ,
      .out_par    (par[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gap_of(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at it.
   task automatic modelStep();
      for (int i = 0; i < 2; i++) begin
         bit ready;
         int slot;
         ready = (m_size[i] != DEPTH);
         if (!rst) begin
            m_head[i] = 0;
            m_size[i] = 0;
            m_gap[i]  = 0;
            m_en[i]   = 1'b0;
            m_a[i]    = '0;
            m_b[i]    = '0;
            m_c[i]    = '0;
            m_acc[i]  = '0;
            m_icnt[i] = '0;
         end else if (flush) begin
            m_head[i] = 0;
            m_size[i] = 0;
            m_gap[i]  = 0;
            m_en[i]   = 1'b0;
         end else begin
            if (m_gap[i] == 0 && m_size[i] > 0) begin
               slot      = m_head[i];
               m_en[i]   = 1'b1;
               m_a[i]    = qa[i][slot];
               m_b[i]    = qb[i][slot];
               m_c[i]    = qc[i][slot];
               m_acc[i]  = m_acc[i] + (qa[i][slot] | qc[i][slot]);
               m_icnt[i] = m_icnt[i] + 16'd1;
               m_head[i] = (m_head[i] + 1) % 8;
               m_size[i] = m_size[i] - 1;
               m_gap[i]  = gap_of(i);
            end else begin
               m_en[i] = 1'b0;
               if (m_gap[i] > 0) m_gap[i] = m_gap[i] - 1;
            end
            if (in_valid && ready) begin
               slot         = (m_head[i] + m_size[i]) % 8;
               qa[i][slot]  = in_a;
               qb[i][slot]  = in_b;
               qc[i][slot]  = in_c;
               m_size[i]    = m_size[i] + 1;
            end
         end
      end
   endtask

   task automatic checkOutput();
      for (int i = 0; i < 2; i++) begin
         string p;
         p = $sformatf("g%0d", gap_of(i));
         chk({p, " out_en"},     32'(en[i]),   32'(m_en[i]));
         chk({p, " out_a"},      32'(oa[i]),   32'(m_a[i]));
         chk({p, " out_b"},      32'(ob[i]),   32'(m_b[i]));
         chk({p, " out_c"},      32'(oc[i]),   32'(m_c[i]));
         chk({p, " shadow_acc"}, 32'(acc[i]),  32'(m_acc[i]));
         chk({p, " count"},      32'(cnt[i]),  32'(m_size[i]));
         chk({p, " issued_cnt"}, 32'(icnt[i]), 32'(m_icnt[i]));
         chk({p, " busy"},       32'(bsy[i]),  32'((m_size[i] != 0) || (m_gap[i] != 0)));
         chk({p, " in_ready"},   32'(rdy[i]),  32'(m_size[i] != DEPTH));
`ifdef ACC_ISSUE_PARITY_EN
         chk({p, " out_par"},    32'(par[i]),  32'(^{m_a[i], m_b[i], m_c[i]}));
`endif
      end
   endtask

   // One clock cycle: drive inputs, step the model at the edge, compare
   // on the following falling edge.
   task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic f, input logic r);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_c     = c;
      flush    = f;
      rst      = r;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 2; i++) begin
         m_head[i] = 0;
         m_size[i] = 0;
         m_gap[i]  = 0;
      end

      // Reset state, then one triplet with the two-edge issue latency.
      doReset();
      chk("reset count", 32'(cnt[0]), 32'd0);
      chk("reset busy",  32'(bsy[1]), 32'd0);
      applyStimulus(1'b1, 12'h00F, 12'h123, 12'h0F0, 1'b0, 1'b1);
      chk("latency en edge1", 32'(en[0]), 32'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
      chk("latency en edge2", 32'(en[0]), 32'd1);
      chk("first out_a",      32'(oa[0]), 32'h00F);
      chk("first out_c",      32'(oc[0]), 32'h0F0);
      chk("first shadow",     32'(acc[0]), 32'h0FF);
      chk("first issued",     32'(icnt[0]), 32'd1);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
      chk("strobe one cycle", 32'(en[0]), 32'd0);
      idle(4);

      // Back-to-back pushes a = 1..4, c = 0.
      doReset();
      for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 12'(k), 12'h055, 12'h000, 1'b0, 1'b1);
      idle(16);
      chk("b2b shadow g0", 32'(acc[0]), 32'h00A);
      chk("b2b shadow g3", 32'(acc[1]), 32'h00A);
      chk("b2b issued g3", 32'(icnt[1]), 32'd4);

      // Continuous fill of the GAP=3 instance with six triplets; data is
      // held until the gapped FIFO has taken it.
      doReset();
      idx = 1;
      for (int k = 0; k < 40 && idx <= 6; k++) begin
         bit take;
         take = (m_size[1] != DEPTH);
         applyStimulus(1'b1, 12'(idx), 12'(idx * 3), 12'h000, 1'b0, 1'b1);
         if (take) idx++;
      end
      idle(30);
      chk("fill issued g3", 32'(icnt[1]), 32'd6);
      chk("fill shadow g3", 32'(acc[1]), 32'h015);

      // Shadow accumulator wrap.
      doReset();
      applyStimulus(1'b1, 12'hFFF, 12'h000, 12'h000, 1'b0, 1'b1);
      applyStimulus(1'b1, 12'hFFF, 12'h000, 12'h000, 1'b0, 1'b1);
      idle(3);
      chk("acc wrap g0", 32'(acc[0]), 32'hFFE);

      // Flush with three queued in the gapped instance and a push pending.
      doReset();
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 12'(16 + k), 12'h0AA, 12'(k), 1'b0, 1'b1);
      chk("preflush count g3", 32'(cnt[1]), 32'd3);
      saved_acc = m_acc[1];
      applyStimulus(1'b1, 12'h777, 12'h777, 12'h777, 1'b1, 1'b1);
      chk("flush count g3",  32'(cnt[1]), 32'd0);
      chk("flush busy g3",   32'(bsy[1]), 32'd0);
      chk("flush en g3",     32'(en[1]), 32'd0);
      chk("flush shadow g3", 32'(acc[1]), 32'(saved_acc));
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
      chk("postflush en g3", 32'(en[1]), 32'd0);
      idle(3);

      // Reset while the gapped instance waits with two queued.
      doReset();
      applyStimulus(1'b1, 12'h001, 12'h000, 12'h000, 1'b0, 1'b1);
      applyStimulus(1'b1, 12'h002, 12'h004, 12'h008, 1'b0, 1'b1);
`ifdef ACC_ISSUE_PARITY_EN
      chk("parity a=1", 32'(par[1]), 32'd1);
`endif
      applyStimulus(1'b1, 12'h003, 12'h005, 12'h009, 1'b0, 1'b1);
      chk("prereset count g3", 32'(cnt[1]), 32'd2);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
      chk("midreset out_a g3",  32'(oa[1]), 32'd0);
      chk("midreset shadow g3", 32'(acc[1]), 32'd0);
      chk("midreset count g3",  32'(cnt[1]), 32'd0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
         chk("no pulse after reset", 32'(en[1]), 32'd0);
      end

      // Randomized traffic with occasional flush and reset.
      for (int k = 0; k < 400; k++) begin
         applyStimulus(($urandom % 4) != 0, 12'($urandom), 12'($urandom), 12'($urandom),
                       ($urandom % 32) == 0, ($urandom % 64) != 0);
      end

      // Run the back-to-back instance until its issue counter wraps.
      doReset();
      for (int k = 0; k < 70000 && m_icnt[0] != 16'hFFFF; k++) begin
         applyStimulus(1'b1, 12'($urandom), 12'($urandom), 12'($urandom), 1'b0, 1'b1);
      end
      applyStimulus(1'b1, 12'h0AB, 12'h0CD, 12'h0EF, 1'b0, 1'b1);
      chk("issued wrap g0", 32'(icnt[0]), 32'd0);
      idle(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
